// File: rtl/serial_word_feeder.sv
// Parallel-to-serial front end for the sequence detector: one buffered word plus
// one shifting word, streamed gaplessly, with a constant idle bit between words.
module serial_word_feeder #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] buf_reg;
    logic             buf_full;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bitcnt;
    logic             last_bit;
    logic             accept;
    logic             load;

    assign last_bit = (bitcnt == CW'(WIDTH - 1));
    assign accept   = in_valid && !buf_full;
    // The buffer moves into the shifter from idle, or straight after the last bit
    assign load     = buf_full && ((state == IDLE) || last_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (buf_full) next_state = SHIFT;
            SHIFT:   if (last_bit && !buf_full) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_reg  <= '0;
            buf_full <= 1'b0;
            shreg    <= '0;
            bitcnt   <= '0;
        end else begin
            if (accept) begin
                buf_reg  <= in_data;
                buf_full <= 1'b1;
            end else if (load) begin
                buf_full <= 1'b0;
            end

            if (load) begin
                shreg  <= buf_reg;
                bitcnt <= '0;
            end else if (state == SHIFT) begin
                if (last_bit) begin
                    bitcnt <= '0;
                end else begin
                    shreg  <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                    bitcnt <= bitcnt + CW'(1);
                end
            end
        end
    end

    always_comb begin
        in_ready  = !buf_full;
        bit_valid = (state == SHIFT);
        word_done = (state == SHIFT) && last_bit;
        busy      = (state == SHIFT) || buf_full;
        x_out     = IDLE_BIT;
        if (state == SHIFT) begin
            x_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: accepted words are expanded into expected
// bits on the handshake and compared as the serial stream emerges.
module tb_serial_word_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       x_out;
    logic       bit_valid;
    logic       word_done;
    logic       busy;

    logic [7:0] l_in_data;
    logic       l_in_valid;
    logic       l_in_ready;
    logic       l_x_out;
    logic       l_bit_valid;
    logic       l_word_done;
    logic       l_busy;

    typedef struct {
        logic x;
        logic done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .x_out(x_out), .bit_valid(bit_valid),
        .word_done(word_done), .busy(busy)
    );

    serial_word_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
        .clk(clk), .rst(rst), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .x_out(l_x_out), .bit_valid(l_bit_valid),
        .word_done(l_word_done), .busy(l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_word(input logic [7:0] w, input bit msb);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            e.x    = msb ? w[7-k] : w[k];
            e.done = (k == 7);
            exp_q.push_back(e);
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (in_ready !== 1'b1 || x_out !== 1'b1 || bit_valid !== 1'b0 || word_done !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL reset_outputs: got rdy=%b x=%b bv=%b wd=%b busy=%b, expected 1 1 0 0 0",
                     in_ready, x_out, bit_valid, word_done, busy);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || x_out !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL idle_after_reset[%0d]: got rdy=%b x=%b bv=%b busy=%b, expected 1 1 0 0",
                         i, in_ready, x_out, bit_valid, busy);
            else passed++;
        end
    endtask

    task automatic test_single_word();
        exp_t e;
        @(posedge clk); #1;
        in_data  = 8'h36;
        in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) $display("[TB] FAIL single_ready: got %b, expected 1", in_ready);
        else passed++;
        push_word(in_data, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (bit_valid !== (i >= 1 && i <= 8) || in_ready !== (i != 0))
                $display("[TB] FAIL single_timing[%0d]: got bv=%b rdy=%b, expected bv=%b rdy=%b",
                         i, bit_valid, in_ready, (i >= 1 && i <= 8), (i != 0));
            else passed++;
            if (i >= 1 && i <= 8 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (x_out !== e.x || word_done !== e.done)
                    $display("[TB] FAIL single_bit[%0d]: got x=%b wd=%b, expected x=%b wd=%b",
                             i, x_out, word_done, e.x, e.done);
                else passed++;
            end else begin
                checks++;
                if (x_out !== 1'b1 || word_done !== 1'b0)
                    $display("[TB] FAIL single_idle[%0d]: got x=%b wd=%b, expected x=1 wd=0", i, x_out, word_done);
                else passed++;
            end
        end
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL single_drain: %0d bits left, expected 0", exp_q.size());
        else passed++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   nacc = 0, nvalid = 0, first = -1, last = -1;
        bit   acc_prev = 1'b0;
        @(posedge clk); #1;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (acc_prev) begin
                checks++;
                if (in_ready !== 1'b0) $display("[TB] FAIL b2b_ready_drop[%0d]: got %b, expected 0", cyc, in_ready);
                else passed++;
            end
            if (bit_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL b2b_spurious[%0d]: got a data bit, expected none", cyc);
                else begin
                    e = exp_q.pop_front();
                    if (x_out !== e.x || word_done !== e.done)
                        $display("[TB] FAIL b2b_bit[%0d]: got x=%b wd=%b, expected x=%b wd=%b",
                                 cyc, x_out, word_done, e.x, e.done);
                    else passed++;
                end
            end
            acc_prev = in_valid && in_ready;
            if (acc_prev) begin
                push_word(in_data, 1'b1);
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc == 1) in_data = 8'h3C;
            else if (nacc >= 2) in_valid = 1'b0;
        end
        checks++;
        if (nacc != 2 || nvalid != 16 || (last - first) != 15 || exp_q.size() != 0)
            $display("[TB] FAIL b2b_gapless: got acc=%0d valid=%0d span=%0d left=%0d, expected 2 16 15 0",
                     nacc, nvalid, last - first, exp_q.size());
        else passed++;
        exp_q.delete();
    endtask

    task automatic test_stall();
        exp_t e;
        int   nacc = 0, nvalid = 0, first = -1, last = -1, nstall = 0;
        @(posedge clk); #1;
        in_data  = 8'($urandom_range(0, 255));
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (bit_valid === 1'b1) begin
                nvalid++;
                if (first < 0) first = cyc;
                last = cyc;
                checks++;
                if (exp_q.size() == 0) $display("[TB] FAIL stall_spurious[%0d]: got a data bit, expected none", cyc);
                else begin
                    e = exp_q.pop_front();
                    if (x_out !== e.x || word_done !== e.done)
                        $display("[TB] FAIL stall_bit[%0d]: got x=%b wd=%b, expected x=%b wd=%b",
                                 cyc, x_out, word_done, e.x, e.done);
                    else passed++;
                end
            end
            if (in_valid && !in_ready) nstall++;
            if (in_valid && in_ready) begin
                push_word(in_data, 1'b1);
                nacc++;
            end
            @(posedge clk); #1;
            if (nacc < 3) in_data = 8'($urandom_range(0, 255));
            else in_valid = 1'b0;
        end
        checks++;
        if (nacc != 3 || nvalid != 24 || (last - first) != 23 || exp_q.size() != 0 || nstall < 6)
            $display("[TB] FAIL stall_stream: got acc=%0d valid=%0d span=%0d left=%0d stalls=%0d, expected 3 24 23 0 >=6",
                     nacc, nvalid, last - first, exp_q.size(), nstall);
        else passed++;
        exp_q.delete();
    endtask

    task automatic test_lsb_first();
        exp_t e;
        @(posedge clk); #1;
        l_in_data  = 8'h01;
        l_in_valid = 1'b1;
        @(negedge clk);
        push_word(l_in_data, 1'b0);
        @(posedge clk); #1;
        l_in_valid = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            checks++;
            if (i >= 1 && i <= 8 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (l_bit_valid !== 1'b1 || l_x_out !== e.x || l_word_done !== e.done)
                    $display("[TB] FAIL lsb_bit[%0d]: got bv=%b x=%b wd=%b, expected bv=1 x=%b wd=%b",
                             i, l_bit_valid, l_x_out, l_word_done, e.x, e.done);
                else passed++;
            end else begin
                if (l_bit_valid !== 1'b0 || l_x_out !== 1'b1)
                    $display("[TB] FAIL lsb_idle[%0d]: got bv=%b x=%b, expected bv=0 x=1", i, l_bit_valid, l_x_out);
                else passed++;
            end
        end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_word();
        @(posedge clk); #1;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_data = 8'h00;
        @(posedge clk);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #2;
        checks++;
        if (bit_valid !== 1'b1 || x_out !== 1'b1 || in_ready !== 1'b0)
            $display("[TB] FAIL midreset_pre: got bv=%b x=%b rdy=%b, expected 1 1 0", bit_valid, x_out, in_ready);
        else passed++;
        rst = 1'b1;
        #1;
        checks++;
        if (x_out !== 1'b1 || bit_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || word_done !== 1'b0)
            $display("[TB] FAIL midreset_async: got x=%b bv=%b busy=%b rdy=%b wd=%b, expected 1 0 0 1 0",
                     x_out, bit_valid, busy, in_ready, word_done);
        else passed++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (bit_valid !== 1'b0 || busy !== 1'b0 || x_out !== 1'b1)
                $display("[TB] FAIL midreset_after[%0d]: got bv=%b busy=%b x=%b, expected 0 0 1",
                         i, bit_valid, busy, x_out);
            else passed++;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_data    = 8'h00;
        in_valid   = 1'b0;
        l_in_data  = 8'h00;
        l_in_valid = 1'b0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_lsb_first();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage of the serial sequence detector: it converts parallel words into the single-bit stream x that the detector samples every clock.
- Accepts WIDTH-bit words over a valid/ready handshake and holds one word in a buffer so back-to-back words stream without gaps.
- Shifts each word out one bit per clock.
- Drives a constant idle bit when it has no data, so the detector always sees a defined input.

Parameters:
- WIDTH, 8, word width in bits; legal values are 2 or greater.
- MSB_FIRST, 1, 1 shifts out MSB first; 0 shifts out LSB first.
- IDLE_BIT, 1, value driven on x_out while no word is being shifted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  parallel word to serialize.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  buffer can accept a word; a transfer occurs on an edge where in_valid and in_ready are both 1.
- x_out  output  1  serial bit stream to the detector's x input.
- bit_valid  output  1  x_out carries a data bit (not idle fill).
- word_done  output  1  high during the last bit of each word.
- busy  output  1  word being shifted, or a word waiting in the buffer.

Behaviour:
- State: buffer register buf[WIDTH] and flag buf_full; shift register shreg[WIDTH]; counter bitcnt of width clog2(WIDTH); flag active. active=0 is IDLE and active=1 is SHIFT.
- Reset (asynchronous, rst=1): buf=0, buf_full=0, shreg=0, bitcnt=0, active=0.
  - Resulting outputs: in_ready=1, x_out=IDLE_BIT, bit_valid=0, word_done=0, busy=0.
- Combinational outputs:
  - in_ready = !buf_full
  - x_out = active ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT
  - bit_valid = active
  - word_done = active && (bitcnt == WIDTH-1)
  - busy = active || buf_full
- Accept: when in_valid && in_ready at an edge, buf <= in_data and buf_full <= 1. in_data is ignored when in_ready=0; the producer holds it.
- IDLE, buf_full=1: at the edge, shreg <= buf, bitcnt <= 0, active <= 1, buf_full <= 0.
- IDLE, buf_full=0: no change.
- SHIFT, bitcnt < WIDTH-1: at the edge, shreg shifts by one toward the output end (left if MSB_FIRST, otherwise right; zero fill) and bitcnt increments.
- SHIFT, bitcnt == WIDTH-1 (last bit):
  - If buf_full: shreg <= buf, bitcnt <= 0, buf_full <= 0, active stays 1. The next word starts with no gap.
  - Else: active <= 0, bitcnt <= 0.
- Latency:
  - A word accepted at edge N is loaded at edge N+1.
  - Its first bit appears on x_out in the cycle after edge N+1; bit k appears after edge N+1+k.
  - word_done is high in the cycle after edge N+WIDTH.
- Simultaneous events:
  - Accept can never coincide with a load from buf, because in_ready=0 whenever buf_full=1.
  - The buffer empties at the load edge and can be refilled on the next edge, well before the next word boundary for any WIDTH >= 2. A continuously valid producer therefore gets a gapless stream.
- Reset during SHIFT: the current word and any buffered word are discarded. x_out returns to IDLE_BIT immediately (asynchronously). No partial word resumes after reset deasserts.
- IDLE_BIT=1 keeps the downstream 0110 detector parked in its initial state between words.

Test Plan:
- Reset, then release with no input → in_ready=1, x_out=1, bit_valid=0, busy=0 for 20 cycles.
- Single word 0x36 accepted at edge N, MSB_FIRST=1 → after edges N+1..N+8, x_out = 0,0,1,1,0,1,1,0 with bit_valid=1. word_done is high only after edge N+8. x_out returns to 1 after edge N+9.
  - Paired with the detector, z pulses during bits 4 and 7 (overlapping 0110 matches).
- Back-to-back words 0xA5, 0x3C with in_valid held high → 16 consecutive bit_valid=1 cycles, no gap.
  - in_ready drops the edge after each accept and rises again after each load.
- Producer stalls while buf_full: in_valid=1 with in_data changing while in_ready=0 → only the value present at the accepting edge is transmitted.
- MSB_FIRST=0, word 0x01 → x_out = 1,0,0,0,0,0,0,0.
- rst asserted at bit 3 of 0xFF with 0x00 buffered → x_out=IDLE_BIT and bit_valid=0 immediately. After release, no bits appear until a new word is accepted.
